alu_issue_ctrl: RTL

Multi-cycle issue controller that drives the registered single-cycle ALU from the requesting side. Accepts one decoded instruction (main ALUOp, funct, operands) per valid/ready handshake and translates it to the 4-bit ALU operation code. It holds the ALU inputs stable across the ALU's registering edge, captures result/zero, evaluates the BEQ/BNE branch decision and returns everything on a valid/ready response channel. It sits between the decode stage and the ALU.

---
 rtl/alu_defs.sv | 32 +++
 rtl/alu_op_decode.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the ALU control path: word size, ALU op codes,
// main-control ALUOp classes, R-type funct fields and issue FSM states.
package alu_defs;

   localparam int WORD_SIZE_DEF = 32;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOP = 4'b1111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ILL   = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_CAPT = 2'b10,
      ST_RESP = 2'b11
   } issue_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: main ALUOp class plus funct field to
// the 4-bit ALU operation; undecodable combinations yield NOP and illegal.
module alu_op_decode
   import alu_defs::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [3:0] op,
   output logic       illegal
);

   // Translate the instruction class and funct field into an ALU op
   always_comb begin
      op      = ALU_NOP;
      illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: op = ALU_ADD;
         ALUOP_SUB: op = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: op = ALU_ADD;
               FUNCT_SUB: op = ALU_SUB;
               FUNCT_AND: op = ALU_AND;
               FUNCT_OR:  op = ALU_OR;
               FUNCT_SLT: op = ALU_SLT;
               default: begin
                  op      = ALU_NOP;
                  illegal = 1'b1;
               end
            endcase
         end
         ALUOP_ILL: begin
            op      = ALU_NOP;
            illegal = 1'b1;
         end
         default: begin
            op      = ALU_NOP;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the registered ALU: accepts one decoded op, holds
// the ALU inputs across its registering edge and returns result and branch.
module alu_issue_ctrl
   import alu_defs::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_aluop,
   input  logic [5:0]           req_funct,
   input  logic                 req_bne,
   input  logic [WORD_SIZE-1:0] req_a,
   input  logic [WORD_SIZE-1:0] req_b,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_SIZE-1:0] resp_result,
   output logic                 resp_zero,
   output logic                 resp_taken,
   output logic                 resp_illegal,
   output logic [3:0]           alu_op,
   output logic [WORD_SIZE-1:0] alu_a,
   output logic [WORD_SIZE-1:0] alu_b,
   input  logic [WORD_SIZE-1:0] alu_result,
   input  logic                 alu_zero,
   output logic                 busy
);

   issue_state_t state_r;
   logic [3:0]   dec_op_s;
   logic         dec_illegal_s;
   logic         branch_r;
   logic         bne_r;
   logic         illegal_r;

   alu_op_decode u_decode (
      .aluop   (req_aluop),
      .funct   (req_funct),
      .op      (dec_op_s),
      .illegal (dec_illegal_s)
   );

   assign req_ready = (state_r == ST_IDLE);

   // Issue FSM; ALU inputs only move at the accepting edge so the ALU,
   // which samples every clock, keeps producing the same result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         alu_op       <= ALU_NOP;
         alu_a        <= '0;
         alu_b        <= '0;
         branch_r     <= 1'b0;
         bne_r        <= 1'b0;
         illegal_r    <= 1'b0;
         resp_valid   <= 1'b0;
         resp_result  <= '0;
         resp_zero    <= 1'b0;
         resp_taken   <= 1'b0;
         resp_illegal <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  alu_op    <= dec_op_s;
                  alu_a     <= req_a;
                  alu_b     <= req_b;
                  branch_r  <= (req_aluop == ALUOP_SUB);
                  bne_r     <= req_bne;
                  illegal_r <= dec_illegal_s;
                  busy      <= 1'b1;
                  state_r   <= ST_EXEC;
               end
            end
            ST_EXEC: state_r <= ST_CAPT;
            ST_CAPT: begin
               resp_result  <= alu_result;
               resp_zero    <= alu_zero;
               resp_taken   <= branch_r & (alu_zero ^ bne_r);
               resp_illegal <= illegal_r;
               resp_valid   <= 1'b1;
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  busy       <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
